// File: rtl/ps2_rx_frame.sv
`timescale 1ns/1ps
// PS/2 device-to-host frame receiver: synchroniser, clock-line glitch filter, frame FSM with timeout, show-ahead byte FIFO.
// Byte visible one cycle after the stop-bit fall_tick; a full FIFO drops the new byte and pulses overflow.
module ps2_rx_frame #(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_AW     = 2,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Synchronisers idle high so reset never fabricates a falling edge.
    logic ps2c_m_q, ps2c_s_q;
    logic ps2d_m_q, ps2d_s_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ps2c_m_q <= 1'b1;
            ps2c_s_q <= 1'b1;
            ps2d_m_q <= 1'b1;
            ps2d_s_q <= 1'b1;
        end else begin
            ps2c_m_q <= ps2c;
            ps2c_s_q <= ps2c_m_q;
            ps2d_m_q <= ps2d;
            ps2d_s_q <= ps2d_m_q;
        end
    end

    logic [FILTER_LEN-1:0] filt_sh_q, filt_sh_d;
    logic                  filt_clk_q, filt_clk_d;
    logic                  fall_tick;

    always_comb begin
        filt_sh_d  = {filt_sh_q[FILTER_LEN-2:0], ps2c_s_q};
        filt_clk_d = filt_clk_q;
        if (filt_sh_q == '0) begin
            filt_clk_d = 1'b0;
        end else if (&filt_sh_q) begin
            filt_clk_d = 1'b1;
        end
        fall_tick = filt_clk_q & ~filt_clk_d;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            filt_sh_q  <= '1;
            filt_clk_q <= 1'b1;
        end else begin
            filt_sh_q  <= filt_sh_d;
            filt_clk_q <= filt_clk_d;
        end
    end

    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          push;
    logic          par_err_d, frm_err_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_d     = par_q;
        push      = 1'b0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        if (state_q == ST_IDLE || fall_tick) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_tick && !ps2d_s_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (fall_tick) begin
                    data_d    = {ps2d_s_q, data_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall_tick) begin
                    par_d   = ps2d_s_q;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_tick) begin
                    state_d = ST_IDLE;
                    // A missing stop bit outranks a parity failure.
                    if (!ps2d_s_q) begin
                        frm_err_d = 1'b1;
                    end else if (^{data_q, par_q}) begin
                        push = 1'b1;
                    end else begin
                        par_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && !fall_tick && to_cnt_q == TO_LAST) begin
            state_d   = ST_IDLE;
            frm_err_d = 1'b1;
            to_cnt_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            data_q    <= 8'h00;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            par_q     <= par_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               full, pop, wr_en, ovf_d;

    // Occupancy can only reach DEPTH, so its MSB alone flags full.
    assign full     = count_q[FIFO_AW];
    assign rx_valid = (count_q != '0);
    assign rx_data  = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign pop      = rd_en & rx_valid;
    assign wr_en    = push & (~full | pop);
    assign ovf_d    = push & full & ~pop;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            parity_err <= par_err_d;
            frame_err  <= frm_err_d;
            overflow   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
`timescale 1ns/1ps
// Bench for ps2_rx_frame: drives PS/2 frames bit by bit, tracks expected FIFO contents and error pulse counts in a queue model.
module tb_ps2_rx_frame;

    localparam int HALF = 30;
    localparam int TO   = 5000;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b0;
    logic       ps2c  = 1'b1;
    logic       ps2d  = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, overflow;

    int n_cmp = 0, n_fail = 0;
    int par_seen = 0, frm_seen = 0, ovf_seen = 0;
    int par_exp = 0, frm_exp = 0, ovf_exp = 0;
    int lat_meas = 11;
    logic [7:0] exp_q[$];

    always #5 CLK = ~CLK;

    ps2_rx_frame #(.FILTER_LEN(8), .FIFO_AW(2), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .RST(RST), .ps2c(ps2c), .ps2d(ps2d), .rd_en(rd_en),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
    );

    // Every high cycle is counted, so a stretched pulse shows up as an extra count.
    always @(negedge CLK) begin
        if (parity_err === 1'b1) par_seen++;
        if (frame_err === 1'b1)  frm_seen++;
        if (overflow === 1'b1)   ovf_seen++;
    end

    function automatic logic [7:0] exp_head();
        return (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    endfunction

    function automatic logic exp_valid();
        return exp_q.size() != 0;
    endfunction

    task automatic send_bit(input logic v, input bit glitch);
        ps2d = v;
        if (glitch) begin
            repeat (10) @(negedge CLK);
            ps2c = 1'b0;
            repeat (5) @(negedge CLK);
            ps2c = 1'b1;
            repeat (HALF - 15) @(negedge CLK);
        end else begin
            repeat (HALF) @(negedge CLK);
        end
        ps2c = 1'b0;
        repeat (HALF) @(negedge CLK);
        ps2c = 1'b1;
    endtask

    // Full frame; rd_en can be pulsed pop_at cycles after the stop-bit fall, lat = cycles until rx_valid seen.
    task automatic send_frame(input logic [7:0] b, input bit flip, input logic stop,
                              input int glitch_idx, input int pop_at, output int lat);
        logic [9:0] bits;
        bits = {(~^b) ^ flip, b, 1'b0};
        lat  = -1;
        for (int i = 0; i < 10; i++) send_bit(bits[i], i == glitch_idx);
        ps2d = stop;
        repeat (HALF) @(negedge CLK);
        ps2c = 1'b0;
        for (int i = 0; i < HALF; i++) begin
            rd_en = (i == pop_at);
            @(negedge CLK);
            if (lat < 0 && rx_valid === 1'b1) lat = i + 1;
        end
        rd_en = 1'b0;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        repeat (HALF) @(negedge CLK);
        if (pop_at >= 0 && exp_q.size() != 0) void'(exp_q.pop_front());
        if (stop !== 1'b1)          frm_exp++;
        else if (flip)              par_exp++;
        else if (exp_q.size() >= 4) ovf_exp++;
        else                        exp_q.push_back(b);
    endtask

    task automatic pop_drive();
        rd_en = 1'b1;
        @(negedge CLK);
        rd_en = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic test_reset();
        RST = 1'b0; ps2c = 1'b1; ps2d = 1'b1; rd_en = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", rx_valid); end
        n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", rx_data); end
        n_cmp++; if ({parity_err, frame_err, overflow} !== 3'b000) begin
            n_fail++; $display("FAIL rst_pulses: got %b want 000", {parity_err, frame_err, overflow}); end
        RST = 1'b1;
        repeat (5) @(negedge CLK);
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_valid: got %b want 0", rx_valid); end
    endtask

    task automatic test_single_frame();
        int lat;
        send_frame(8'h1C, 1'b0, 1'b1, -1, -1, lat);
        n_cmp++; if (lat < 10 || lat > 14) begin n_fail++; $display("FAIL t1_latency: got %0d cycles want 10..14", lat); end
        else lat_meas = lat;
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h1C) begin
            n_fail++; $display("FAIL t1_byte: got valid=%b data=%h want valid=1 data=1c", rx_valid, rx_data); end
        n_cmp++; if (par_seen != par_exp || frm_seen != frm_exp || ovf_seen != ovf_exp) begin
            n_fail++; $display("FAIL t1_pulses: got %0d/%0d/%0d want %0d/%0d/%0d", par_seen, frm_seen, ovf_seen, par_exp, frm_exp, ovf_exp); end
        pop_drive();
        n_cmp++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            n_fail++; $display("FAIL t1_pop: got valid=%b data=%h want valid=0 data=00", rx_valid, rx_data); end
    endtask

    task automatic test_two_frames();
        int lat;
        send_frame(8'hF0, 1'b0, 1'b1, -1, -1, lat);
        send_frame(8'h1C, 1'b0, 1'b1, -1, -1, lat);
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== exp_head()) begin
            n_fail++; $display("FAIL t2_head0: got valid=%b data=%h want valid=1 data=%h", rx_valid, rx_data, exp_head()); end
        pop_drive();
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== exp_head()) begin
            n_fail++; $display("FAIL t2_head1: got valid=%b data=%h want valid=1 data=%h", rx_valid, rx_data, exp_head()); end
        pop_drive();
        n_cmp++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            n_fail++; $display("FAIL t2_empty: got valid=%b data=%h want valid=0 data=00", rx_valid, rx_data); end
    endtask

    task automatic test_errors();
        int lat;
        send_frame(8'h1C, 1'b1, 1'b1, -1, -1, lat);
        n_cmp++; if (par_seen != par_exp || frm_seen != frm_exp || rx_valid !== 1'b0) begin
            n_fail++; $display("FAIL t3_parity: got par=%0d frm=%0d valid=%b want par=%0d frm=%0d valid=0", par_seen, frm_seen, rx_valid, par_exp, frm_exp); end
        send_frame(8'h1C, 1'b0, 1'b0, -1, -1, lat);
        n_cmp++; if (par_seen != par_exp || frm_seen != frm_exp || rx_valid !== 1'b0) begin
            n_fail++; $display("FAIL t3_stop: got par=%0d frm=%0d valid=%b want par=%0d frm=%0d valid=0", par_seen, frm_seen, rx_valid, par_exp, frm_exp); end
        send_frame(8'h55, 1'b1, 1'b0, -1, -1, lat);
        n_cmp++; if (par_seen != par_exp || frm_seen != frm_exp) begin
            n_fail++; $display("FAIL t3_both: got par=%0d frm=%0d want par=%0d frm=%0d", par_seen, frm_seen, par_exp, frm_exp); end
    endtask

    task automatic test_overflow();
        int lat;
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b0, 1'b1, -1, -1, lat);
        n_cmp++; if (ovf_seen != ovf_exp) begin n_fail++; $display("FAIL t4_ovf: got %0d want %0d", ovf_seen, ovf_exp); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (rx_valid !== 1'b1 || rx_data !== exp_head()) begin
                n_fail++; $display("FAIL t4_drain%0d: got valid=%b data=%h want valid=1 data=%h", k, rx_valid, rx_data, exp_head()); end
            pop_drive();
        end
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL t4_drained: got valid=%b want 0", rx_valid); end
        for (int k = 0; k < 4; k++) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, -1, -1, lat);
        send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, -1, lat_meas - 1, lat);
        n_cmp++; if (ovf_seen != ovf_exp) begin n_fail++; $display("FAIL t4_pushpop_ovf: got %0d want %0d", ovf_seen, ovf_exp); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (rx_valid !== 1'b1 || rx_data !== exp_head()) begin
                n_fail++; $display("FAIL t4_full%0d: got valid=%b data=%h want valid=1 data=%h", k, rx_valid, rx_data, exp_head()); end
            pop_drive();
        end
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL t4_occupancy: got valid=%b want 0 after 4 pops", rx_valid); end
    endtask

    task automatic test_glitch();
        int lat;
        ps2d = 1'b0;
        repeat (20) @(negedge CLK);
        ps2c = 1'b0;
        repeat (3) @(negedge CLK);
        ps2c = 1'b1;
        repeat (20) @(negedge CLK);
        ps2d = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, 4, -1, lat);
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
            n_fail++; $display("FAIL t5_byte: got valid=%b data=%h want valid=1 data=5a", rx_valid, rx_data); end
        n_cmp++; if (par_seen != par_exp || frm_seen != frm_exp || ovf_seen != ovf_exp) begin
            n_fail++; $display("FAIL t5_pulses: got %0d/%0d/%0d want %0d/%0d/%0d", par_seen, frm_seen, ovf_seen, par_exp, frm_exp, ovf_exp); end
        pop_drive();
    endtask

    task automatic test_timeout();
        int lat, cyc, f0;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        ps2d = 1'b1;
        f0 = frm_seen;
        cyc = 0;
        while (frm_seen == f0 && cyc < 8000) begin
            @(negedge CLK);
            cyc++;
        end
        frm_exp++;
        n_cmp++; if (frm_seen != frm_exp) begin n_fail++; $display("FAIL t6_timeout_err: got %0d want %0d", frm_seen, frm_exp); end
        n_cmp++; if (cyc < TO - HALF - 5 || cyc > TO + 20) begin
            n_fail++; $display("FAIL t6_timeout_time: got %0d cycles want %0d..%0d", cyc, TO - HALF - 5, TO + 20); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL t6_timeout_nobyte: got valid=%b want 0", rx_valid); end
        send_frame(8'h29, 1'b0, 1'b1, -1, -1, lat);
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h29) begin
            n_fail++; $display("FAIL t6_after_timeout: got valid=%b data=%h want valid=1 data=29", rx_valid, rx_data); end
        pop_drive();
    endtask

    task automatic test_reset_mid_frame();
        int lat;
        send_frame(8'h33, 1'b0, 1'b1, -1, -1, lat);
        n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL t6_prefill: got valid=%b want 1", rx_valid); end
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        n_cmp++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            n_fail++; $display("FAIL t6_rst_clear: got valid=%b data=%h want valid=0 data=00", rx_valid, rx_data); end
        repeat (TO + 500) @(negedge CLK);
        n_cmp++; if (par_seen != par_exp || frm_seen != frm_exp || ovf_seen != ovf_exp) begin
            n_fail++; $display("FAIL t6_rst_silent: got %0d/%0d/%0d want %0d/%0d/%0d", par_seen, frm_seen, ovf_seen, par_exp, frm_exp, ovf_exp); end
        send_frame(8'h29, 1'b0, 1'b1, -1, -1, lat);
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h29) begin
            n_fail++; $display("FAIL t6_after_rst: got valid=%b data=%h want valid=1 data=29", rx_valid, rx_data); end
        pop_drive();
    endtask

    task automatic test_random();
        int lat, kind, npop;
        logic [7:0] b;
        for (int n = 0; n < 12; n++) begin
            b    = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 7);
            send_frame(b, kind == 0, kind != 1, -1, -1, lat);
            n_cmp++; if (rx_valid !== exp_valid() || rx_data !== exp_head() ||
                         par_seen != par_exp || frm_seen != frm_exp || ovf_seen != ovf_exp) begin
                n_fail++; $display("FAIL rnd%0d_state: got valid=%b data=%h p/f/o=%0d/%0d/%0d want valid=%b data=%h p/f/o=%0d/%0d/%0d",
                    n, rx_valid, rx_data, par_seen, frm_seen, ovf_seen, exp_valid(), exp_head(), par_exp, frm_exp, ovf_exp); end
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) begin
                pop_drive();
                n_cmp++; if (rx_valid !== exp_valid() || rx_data !== exp_head()) begin
                    n_fail++; $display("FAIL rnd%0d_pop%0d: got valid=%b data=%h want valid=%b data=%h",
                        n, k, rx_valid, rx_data, exp_valid(), exp_head()); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_two_frames();
        test_errors();
        test_overflow();
        test_glitch();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
